// File: rtl/div16_seq.sv
// Multi-cycle 16-bit unsigned restoring divider (DIVU path): one quotient bit
// per clock through a shared add/subtract unit, with start/busy/done handshake.

module addsub16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] b_eff;

  // Subtract is a + ~b + 1; co then means "no borrow" (a >= b).
  assign b_eff   = sub ? ~b : b;
  assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {16'b0, ci ^ sub};
endmodule

module div16_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   r_q, q_q, dvsr;
  logic [WIDTH-1:0]   shifted, diff, r_next, q_next;
  logic               co, ge, accept, last_iter;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  addsub16 u_addsub (
    .a   (shifted),
    .b   (dvsr),
    .sub (1'b1),
    .ci  (1'b0),
    .s   (diff),
    .co  (co)
  );

  // A set R[15] means the shifted value exceeds 16 bits, so it beats any divisor.
  assign ge     = r_q[WIDTH-1] | co;
  assign r_next = ge ? diff : shifted;
  assign q_next = {q_q[WIDTH-2:0], ge};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start)               state_next = (divisor == '0) ? S_DONE : S_RUN;
        else if (state == S_DONE) state_next = S_IDLE;
      end
      S_RUN:   if (last_iter) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake decode used by the datapath and output registers.
  always_comb begin
    accept    = start && (state != S_RUN);
    last_iter = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvsr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      busy <= (state_next == S_RUN);
      done <= (state_next == S_DONE);
      if (accept) begin
        dvsr     <= divisor;
        div_zero <= (divisor == '0);
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
        end else begin
          cnt <= '0;
          r_q <= '0;
          q_q <= dividend;
        end
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        r_q <= r_next;
        q_q <= q_next;
        if (last_iter) begin
          quotient  <= q_next;
          remainder <= r_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed corner cases plus random
// operand pairs checked against plain integer division.

module tb_div16_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div16_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one op in cycle 0 and follow it to done; inputs are scrambled
  // after the accept edge so any late sampling shows up as a wrong result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez);
    int lat, busy_cnt, exp_lat;
    logic [15:0] hq, hr;
    exp_lat = (b == 16'd0) ? 1 : 17;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done && lat < 40) begin
      busy_cnt += int'(busy);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, (b == 16'd0) ? 0 : 16);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, div_zero, ez);
    hq = quotient; hr = remainder;
    @(negedge clk);
    check({tag, " done pulse width"}, done, 1'b0);
    check({tag, " held result"}, {quotient, remainder}, {hq, hr});
  endtask

  initial begin
    logic [15:0] ta [0:20];
    logic [15:0] tb [0:20];
    int done_cyc [$];
    logic [31:0] res [$];

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, done, div_zero, quotient, remainder}, '0);
    reset = 1'b0;

    run_op("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    run_op("FFFF/8001", 16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0);
    run_op("FFFF/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    run_op("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
    run_op("0/9", 16'd0, 16'd9, 16'd0, 16'd0, 1'b0);

    // Start held high for cycles 0..20 with fresh operands every cycle.
    for (int i = 0; i <= 20; i++) begin
      ta[i] = 16'($urandom);
      tb[i] = 16'($urandom_range(1, 16'hFFFF));
    end
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(c);
        res.push_back({quotient, remainder});
      end
      start    = (c <= 20);
      dividend = (c <= 20) ? ta[c] : 16'd0;
      divisor  = (c <= 20) ? tb[c] : 16'd0;
    end
    start = 1'b0;
    check("held start done count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      check("held start 1st done cycle", done_cyc[0], 17);
      check("held start 1st result", res[0], {ta[0] / tb[0], ta[0] % tb[0]});
      check("held start 2nd done cycle", done_cyc[1], 34);
      check("held start 2nd result", res[1], {ta[17] / tb[17], ta[17] % tb[17]});
    end

    // Reset in cycle 8 of a RUN aborts the op without a done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort outputs", {busy, done, div_zero, quotient, remainder}, '0);
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        seen += int'(done) + int'(busy);
      end
      check("abort no done/busy", seen, 0);
    end
    run_op("50/5 after abort", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0);

    // Random pairs vs. integer division (occasional zero divisor mixed in).
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'h8000 | 16'($urandom);
        default: b = 16'($urandom);
      endcase
      if (b == 16'd0) run_op("rand", a, b, 16'hFFFF, a, 1'b1);
      else            run_op("rand", a, b, a / b, a % b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
